// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame parser.
//   state_t       : parser FSM states
//   ERR_*         : err_code encodings reported with frame_err
//   SYNC_BYTE_DEF : default frame start marker
//   len_ok()      : legal LEN field test (1..max_len)
package uart_pkg;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHECK   = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CHK  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // LEN field is legal when it is non-zero and fits the payload buffer
  function automatic logic len_ok(input logic [7:0] len_byte, input int unsigned max_len);
    return (len_byte != 8'h00) && (32'(len_byte) <= max_len);
  endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte-stream interface around the frame parser.
//   rx_byte/rx_valid     : strobed bytes from uart_rx (no backpressure)
//   out_data/out_valid/out_ready/out_last : verified payload stream
//   frame_done/frame_err/err_code/rx_overrun : status pulses and last error cause
// slave modport is the parser side, master modport is the surrounding logic.
interface uart_frame_parser_if;

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;
  logic       rx_overrun;

  modport slave (
    input  rx_byte,
    input  rx_valid,
    input  out_ready,
    output out_data,
    output out_valid,
    output out_last,
    output frame_done,
    output frame_err,
    output err_code,
    output rx_overrun
  );

  modport master (
    output rx_byte,
    output rx_valid,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  out_last,
    input  frame_done,
    input  frame_err,
    input  err_code,
    input  rx_overrun
  );

endinterface

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register file, one synchronous write port and
// one combinational read port. Contents are not reset.
//   clk                 : system clock
//   we, waddr, wdata    : write port
//   raddr, rdata_c      : asynchronous read port
module uart_frame_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata_c
);

  logic [7:0] mem_q [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // read port
  assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Frames the uart_rx byte stream as SYNC, LEN, payload, CHK. The payload is
// buffered and only released on the out_* stream once LEN and the 8-bit
// additive checksum (LEN + payload bytes) have been verified. Bad frames are
// discarded with a frame_err pulse and err_code.
//   clk, rst   : clock, asynchronous active-high reset
//   bus.slave  : rx_byte/rx_valid in, out_data/out_valid/out_ready/out_last,
//                frame_done, frame_err, err_code, rx_overrun
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int unsigned MAX_LEN      = 16,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CLKS = 4340
) (
  input  logic                clk,
  input  logic                rst,
  uart_frame_parser_if.slave  bus
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  state_t        state_q,      state_d;
  logic [LW-1:0] len_q,        len_d;
  logic [LW-1:0] wr_ptr_q,     wr_ptr_d;
  logic [LW-1:0] rd_ptr_q,     rd_ptr_d;
  logic [7:0]    sum_q,        sum_d;
  logic [TW-1:0] tmo_q,        tmo_d;
  logic [7:0]    out_data_q,   out_data_d;
  logic          out_valid_q,  out_valid_d;
  logic          out_last_q,   out_last_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_err_q,  frame_err_d;
  logic [1:0]    err_code_q,   err_code_d;
  logic          rx_overrun_q, rx_overrun_d;

  logic          buf_we_c;
  logic [7:0]    buf_rdata_c;

  // payload storage; read address follows the next read pointer so the
  // registered out_data lines up with rd_ptr_q
  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .we      (buf_we_c),
    .waddr   (AW'(wr_ptr_q)),
    .wdata   (bus.rx_byte),
    .raddr   (AW'(rd_ptr_d)),
    .rdata_c (buf_rdata_c)
  );

  // next-state, datapath and output decode
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    sum_d        = sum_q;
    tmo_d        = tmo_q;
    err_code_d   = err_code_q;
    frame_err_d  = 1'b0;
    frame_done_d = 1'b0;
    rx_overrun_d = 1'b0;
    buf_we_c     = 1'b0;

    case (state_q)
      HUNT: begin
        if (bus.rx_valid && (bus.rx_byte == SYNC_BYTE)) begin
          state_d = LEN;
          tmo_d   = '0;
        end
      end

      LEN: begin
        if (bus.rx_valid) begin
          if (!len_ok(bus.rx_byte, MAX_LEN)) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = HUNT;
          end else begin
            len_d    = LW'(bus.rx_byte);
            sum_d    = bus.rx_byte;
            wr_ptr_d = '0;
            state_d  = PAYLOAD;
          end
        end
      end

      // sync bytes here are ordinary data
      PAYLOAD: begin
        if (bus.rx_valid) begin
          buf_we_c = 1'b1;
          sum_d    = sum_q + bus.rx_byte;
          wr_ptr_d = wr_ptr_q + LW'(1);
          if (wr_ptr_q == (len_q - LW'(1))) begin
            state_d = CHECK;
          end
        end
      end

      CHECK: begin
        if (bus.rx_valid) begin
          if (bus.rx_byte == sum_q) begin
            state_d  = DRAIN;
            rd_ptr_d = '0;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
            state_d     = HUNT;
          end
        end
      end

      // incoming bytes cannot be held off, so they are dropped and flagged
      DRAIN: begin
        if (bus.rx_valid) begin
          rx_overrun_d = 1'b1;
        end
        if (out_valid_q && bus.out_ready) begin
          if (rd_ptr_q == (len_q - LW'(1))) begin
            frame_done_d = 1'b1;
            state_d      = HUNT;
          end else begin
            rd_ptr_d = rd_ptr_q + LW'(1);
          end
        end
      end

      default: begin
        state_d = HUNT;
      end
    endcase

    // inter-byte timeout; a byte arriving on the last count wins
    if ((state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHECK)) begin
      if (bus.rx_valid) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        frame_err_d = 1'b1;
        err_code_d  = ERR_TMO;
        state_d     = HUNT;
        tmo_d       = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    // output stream is driven exactly while the next state is DRAIN
    out_valid_d = (state_d == DRAIN);
    out_data_d  = out_valid_d ? buf_rdata_c : 8'h00;
    out_last_d  = out_valid_d && (rd_ptr_d == (len_q - LW'(1)));
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      len_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      sum_q        <= '0;
      tmo_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      rx_overrun_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      sum_q        <= sum_d;
      tmo_q        <= tmo_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.err_code   = err_code_q;
  assign bus.rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: a table of frames with their
// expected outcome, a scoreboard of expected payload bytes and error codes,
// and hand-written sequences for timeout, backpressure/overrun and reset.
module tb_uart_frame_parser;
  import uart_pkg::*;

  localparam int unsigned MAX_LEN      = 16;
  localparam int unsigned TIMEOUT_CLKS = 4340;

  localparam int K_OK  = 0;
  localparam int K_LEN = 1;
  localparam int K_CHK = 2;
  localparam int K_IGN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_frame_parser_if bus ();

  uart_frame_parser #(
    .MAX_LEN      (MAX_LEN),
    .SYNC_BYTE    (8'hA5),
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int           n;
    logic [159:0] b;
    int           kind;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q [$];
  logic [1:0] err_q [$];
  int         ovr_exp = 0;
  int         ovr_seen = 0;
  bit         rdy_rand = 1'b0;
  logic       pend_done = 1'b0;
  logic       prev_hold = 1'b0;
  logic       prev_adv = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int n, input logic [159:0] b, input int kind);
    vec_t v;
    v.n    = n;
    v.b    = b;
    v.kind = kind;
    return v;
  endfunction

  function automatic logic [7:0] byte_of(input vec_t v, input int i);
    return v.b[(v.n - 1 - i) * 8 +: 8];
  endfunction

  // scoreboard / protocol monitor, sampling on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      pend_done = 1'b0;
      prev_hold = 1'b0;
      prev_adv  = 1'b0;
    end else begin
      chk("frame_done", 32'(bus.frame_done), 32'(pend_done));
      pend_done = 1'b0;
      if (!bus.out_valid) chk("idle_data", 32'(bus.out_data), 32'h0);
      if (bus.frame_err) begin
        chk("err_vs_valid", 32'(bus.out_valid), 32'h0);
        if (err_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_err: got code %0h expected no error at %0t", bus.err_code, $time);
        end else begin
          chk("err_code", 32'(bus.err_code), 32'(err_q.pop_front()));
        end
      end
      if (prev_hold) begin
        chk("hold_valid", 32'(bus.out_valid), 32'h1);
        chk("hold_data", 32'(bus.out_data), 32'(prev_data));
      end
      if (prev_adv) chk("stream_valid", 32'(bus.out_valid), 32'h1);
      if (bus.rx_overrun) ovr_seen++;
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      prev_adv  = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h expected no output at %0t", bus.out_data, $time);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("out_data", 32'(bus.out_data), 32'(e[7:0]));
          chk("out_last", 32'(bus.out_last), 32'(e[8]));
        end
        if (bus.out_last) pend_done = 1'b1;
        else prev_adv = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0 || pend_done || bus.out_valid) && k < budget) begin
      tick();
      k++;
    end
    chk({name, "_settled"}, 32'(k < budget), 32'h1);
    if (k >= budget) begin
      exp_q.delete();
      err_q.delete();
    end
    rdy_rand      = 1'b0;
    bus.out_ready = 1'b1;
    idle(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    vec_t vt [9];
    int   c;

    bus.rx_byte   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.out_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_out_last", 32'(bus.out_last), 32'h0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'h0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
    chk("rst_err_code", 32'(bus.err_code), 32'h0);
    chk("rst_overrun", 32'(bus.rx_overrun), 32'h0);
    rst = 1'b0;
    tick();

    vt[0] = mk(6, 160'({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}), K_OK);
    vt[1] = mk(6, 160'({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68}), K_CHK);
    vt[2] = mk(6, 160'({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}), K_OK);
    vt[3] = mk(2, 160'({8'hA5, 8'h00}), K_LEN);
    vt[4] = mk(2, 160'({8'hA5, 8'h11}), K_LEN);
    vt[5] = mk(3, 160'({8'h00, 8'hFF, 8'h5A}), K_IGN);
    vt[6] = mk(4, 160'({8'hA5, 8'h01, 8'hA5, 8'hA6}), K_OK);
    vt[7] = mk(19, 160'({8'hA5, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                         8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E,
                         8'h0F, 8'h10, 8'h98}), K_OK);
    vt[8] = mk(5, 160'({8'hA5, 8'h02, 8'hFF, 8'h01, 8'h02}), K_OK);

    for (int i = 0; i < 9; i++) begin
      if (vt[i].kind == K_OK) begin
        for (int j = 2; j < vt[i].n - 1; j++) exp_q.push_back({(j == vt[i].n - 2), byte_of(vt[i], j)});
      end else if (vt[i].kind != K_IGN) begin
        err_q.push_back(2'(vt[i].kind));
      end
      rdy_rand = (i == 2) || (i == 7);
      for (int j = 0; j < vt[i].n; j++) begin
        send_byte(byte_of(vt[i], j));
        idle($urandom_range(0, 2));
      end
      wait_idle($sformatf("vec%0d", i), 200);
    end

    // timeout latency from the last received byte
    err_q.push_back(ERR_TMO);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'hAA);
    c = 0;
    do begin
      tick();
      c++;
    end while (!bus.frame_err && c < int'(TIMEOUT_CLKS) + 20);
    chk("tmo_latency", 32'(c), 32'(TIMEOUT_CLKS));
    chk("tmo_code", 32'(bus.err_code), 32'(ERR_TMO));
    wait_idle("tmo", 50);

    // byte on the final counter value still continues the frame
    exp_q.push_back({1'b0, 8'hAA});
    exp_q.push_back({1'b1, 8'hBB});
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'hAA);
    idle(TIMEOUT_CLKS - 1);
    send_byte(8'hBB);
    send_byte(8'h67);
    wait_idle("tmo_edge", 100);

    // one cycle later the frame is already gone; trailing bytes are ignored
    err_q.push_back(ERR_TMO);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'hAA);
    idle(TIMEOUT_CLKS);
    send_byte(8'hBB);
    send_byte(8'h67);
    wait_idle("tmo_late", 100);

    // backpressure with an overrun byte during drain
    bus.out_ready = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h69);
    idle(2);
    chk("bp_valid", 32'(bus.out_valid), 32'h1);
    chk("bp_data", 32'(bus.out_data), 32'h11);
    chk("bp_last", 32'(bus.out_last), 32'h0);
    send_byte(8'h55);
    ovr_exp++;
    chk("ovr_pulse", 32'(bus.rx_overrun), 32'h1);
    chk("ovr_data", 32'(bus.out_data), 32'h11);
    idle(3);
    chk("ovr_pulse_end", 32'(bus.rx_overrun), 32'h0);
    chk("bp_hold_data", 32'(bus.out_data), 32'h11);
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b1, 8'h33});
    bus.out_ready = 1'b1;
    wait_idle("bp", 50);

    // asynchronous reset in the middle of a payload
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h01);
    send_byte(8'h02);
    #2 rst = 1'b1;
    #1;
    chk("mrst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("mrst_out_data", 32'(bus.out_data), 32'h0);
    chk("mrst_frame_err", 32'(bus.frame_err), 32'h0);
    chk("mrst_err_code", 32'(bus.err_code), 32'h0);
    chk("mrst_overrun", 32'(bus.rx_overrun), 32'h0);
    #2 rst = 1'b0;
    tick();
    exp_q.push_back({1'b1, 8'h7E});
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h7E);
    send_byte(8'h7F);
    wait_idle("post_rst", 50);

    chk("overrun_count", 32'(ovr_seen), 32'(ovr_exp));
    chk("leftover", 32'(exp_q.size() + err_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
Sits directly downstream of uart_rx and consumes its byte_recv/recv_valid stream. It frames the bytes into packets: SYNC, LEN, payload, CHK. It buffers the payload, checks the length and an 8-bit additive checksum, and releases the payload only after the frame is fully verified. Release is over a valid/ready byte stream to the command/register logic. Bad frames are discarded and reported with an error pulse and code.

Parameters:
MAX_LEN, 16, maximum payload bytes per frame (buffer depth); legal LEN is 1..MAX_LEN.
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_CLKS, 4340, inter-byte timeout in clk cycles (two byte times at 217 clks/bit); must be >= 2.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-high reset.
rx_byte  input  8  received byte from uart_rx; sampled only when rx_valid=1.
rx_valid  input  1  single-cycle strobe from uart_rx; no backpressure possible.
out_data  output  8  payload byte; 8'h00 whenever out_valid=0.
out_valid  output  1  payload byte available.
out_ready  input  1  consumer accepts; transfer when out_valid && out_ready at posedge clk.
out_last  output  1  high with out_valid on the final payload byte.
frame_done  output  1  one-cycle pulse after the last payload byte transfers.
frame_err  output  1  one-cycle pulse when a frame is discarded.
err_code  output  2  cause of last error: 01 bad LEN, 10 checksum mismatch, 11 timeout; updated with frame_err and held until the next error.
rx_overrun  output  1  one-cycle pulse when a byte arrives in DRAIN and is dropped.

Behaviour:
- Reset (async, rst=1): state=HUNT; all outputs 0; err_code=00; pointers, sum and timeout counter cleared. Buffer contents need no reset.
- All outputs are registered. A pulse caused by an event at posedge N is high during cycle N+1 only.
- HUNT: on rx_valid with rx_byte==SYNC_BYTE -> LEN. Other bytes are ignored silently. No timeout runs.
- LEN: on rx_valid:
  - byte==0 or byte>MAX_LEN -> frame_err, err_code=01 -> HUNT.
  - otherwise latch len, sum<=byte, wr_ptr<=0 -> PAYLOAD.
- PAYLOAD: on rx_valid: buf[wr_ptr]<=byte, sum<=sum+byte (mod 256), wr_ptr++. The byte with wr_ptr==len-1 moves to CHECK. SYNC_BYTE inside the payload is plain data; there is no resync.
- CHECK: on rx_valid:
  - byte==sum -> DRAIN, rd_ptr<=0.
  - else frame_err, err_code=10 -> HUNT.
- Timeout (LEN, PAYLOAD, CHECK only):
  - Counter clears on entering LEN and on every rx_valid, and increments otherwise.
  - When it reaches TIMEOUT_CLKS-1 with no rx_valid that cycle -> frame_err, err_code=11 -> HUNT.
  - rx_valid in the same cycle wins over the timeout.
- DRAIN:
  - out_valid=1, out_data=buf[rd_ptr], out_last=(rd_ptr==len-1).
  - Each handshake increments rd_ptr. out_data is stable while out_valid && !out_ready.
  - Handshake on the last byte -> out_valid drops next cycle, frame_done pulses, state -> HUNT.
  - Max throughput is one byte per cycle.
- rx_valid while in DRAIN: byte dropped, rx_overrun pulses, drain unaffected. If that byte was SYNC_BYTE it is not used to start a frame.
- Error pulses never coincide with out_valid; a discarded frame produces no out_valid.
- Widths: len and pointers are $clog2(MAX_LEN+1) bits; the checksum is 8 bits and wraps.

Decomposition:
- uart_pkg holds:
  - the state enum (HUNT, LEN, PAYLOAD, CHECK, DRAIN);
  - err_code constants (ERR_LEN=2'b01, ERR_CHK=2'b10, ERR_TMO=2'b11);
  - the default SYNC_BYTE.
- One sub-module, uart_frame_buf: MAX_LEN x 8 register file with one synchronous write port and one combinational read port. The FSM, checksum and timeout stay in the top level.

Test Plan:
- Good frame: A5 03 11 22 33 69 with out_ready=1 -> out_data 11,22,33 on consecutive cycles, out_last with 33, frame_done pulse 1 cycle later, frame_err never.
- Bad checksum: A5 03 11 22 33 68 -> frame_err pulse with err_code=10, no out_valid. A following good frame decodes normally.
- Bad length: A5 00 -> err_code=01; A5 11 (17>16) -> err_code=01. Leading garbage 00 FF 5A before A5 is ignored with no error.
- Timeout: A5 02 AA then idle -> frame_err with err_code=11 exactly TIMEOUT_CLKS cycles after the AA strobe. Also, a byte landing on cycle TIMEOUT_CLKS-1 -> no error.
- Backpressure/overrun: good frame with out_ready=0; inject 55 during DRAIN -> rx_overrun pulse, out_data holds 11. Raise out_ready -> 11,22,33, then frame_done.
- Reset mid-PAYLOAD (after A5 04 01 02) -> all outputs 0 immediately. A subsequent A5 01 7E 7F -> out_data 7E with out_last, frame_done.
